// File: rtl/ex_mem_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe_pkg
// Description : Shared defines for the EX/MEM pipeline register: reset
//               polarity, write-enable levels, the no-op register address,
//               memory-operation codes and the pipeline occupancy states.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ex_mem_pipe_pkg;

    // Reset is asserted when rst_n carries this level.
    localparam logic RST_ACTIVE    = 1'b0;

    // Register-file write enable levels.
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // x0 is hard-wired to zero, so a write to it never needs forwarding.
    localparam int   NOP_REG_ADDR  = 0;

    // Memory-operation codes; MEM_NOP means no memory access.
    localparam int   MEM_NOP = 0;
    localparam int   MEM_LB  = 1;
    localparam int   MEM_LH  = 2;
    localparam int   MEM_LW  = 3;
    localparam int   MEM_LBU = 4;
    localparam int   MEM_LHU = 5;
    localparam int   MEM_SB  = 6;
    localparam int   MEM_SH  = 7;
    localparam int   MEM_SW  = 8;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing held
        ST_ONE   = 2'd1,   // head only
        ST_TWO   = 2'd2    // head and skid
    } pipe_state_e;

endpackage : ex_mem_pipe_pkg
`default_nettype wire

// File: rtl/ex_mem_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe_if
// Description : Bundle of the EX->MEM handshake, payload, control and
//               forwarding-tap signals.
//   rdy, flush              : global enable / synchronous kill
//   ex_valid/ex_ready/ex_*  : upstream (EX) entry and handshake
//   mem_valid/mem_ready/... : downstream (MEM) head entry and handshake
//   fwd_*                   : forwarding tap from the head entry
//   modport slave           : the pipeline register side
//   modport master          : the surrounding pipeline side
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_mem_pipe_if #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int MEMOP_W    = 4
);
    logic                  rdy;
    logic                  flush;

    logic                  ex_valid;
    logic                  ex_ready;
    logic [REG_ADDR_W-1:0] ex_wd;
    logic                  ex_wreg;
    logic [DATA_W-1:0]     ex_wdata;
    logic [MEMOP_W-1:0]    ex_mem_op;
    logic [DATA_W-1:0]     ex_mem_addr;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_wd;
    logic                  mem_wreg;
    logic [DATA_W-1:0]     mem_wdata;
    logic [MEMOP_W-1:0]    mem_mem_op;
    logic [DATA_W-1:0]     mem_mem_addr;

    logic [REG_ADDR_W-1:0] fwd_wd;
    logic                  fwd_wreg;
    logic [DATA_W-1:0]     fwd_wdata;

    modport slave (
        input  rdy, flush,
        input  ex_valid, ex_wd, ex_wreg, ex_wdata, ex_mem_op, ex_mem_addr,
        output ex_ready,
        input  mem_ready,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_mem_op, mem_mem_addr,
        output fwd_wd, fwd_wreg, fwd_wdata
    );

    modport master (
        output rdy, flush,
        output ex_valid, ex_wd, ex_wreg, ex_wdata, ex_mem_op, ex_mem_addr,
        input  ex_ready,
        output mem_ready,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_mem_op, mem_mem_addr,
        input  fwd_wd, fwd_wreg, fwd_wdata
    );

endinterface : ex_mem_pipe_if
`default_nettype wire

// File: rtl/ex_mem_pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One pipeline entry: a valid bit plus a payload register.
//               clear has priority over load; with neither, the slot holds.
//   clk, rst_n : clock, asynchronous active-low reset
//   load, d    : capture d and mark the slot valid
//   clear      : mark the slot empty (payload is left as is)
//   valid, q   : registered valid bit and payload
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
    import ex_mem_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         load,
    input  wire logic         clear,
    input  wire logic [W-1:0] d,
    output logic              valid,
    output logic [W-1:0]      q
);

    logic         r_valid;
    logic [W-1:0] r_q;

    // All-zero payload is the no-op register address with the zero word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACTIVE) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_q     <= d;
        end
    end

    assign valid = r_valid;
    assign q     = r_q;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_pipe
// Description : EX/MEM pipeline register built as a two-entry skid buffer
//               (head + skid) so ex_ready depends only on registered state.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ex_mem_pipe_if.slave (handshakes, payload, rdy, flush,
//                forwarding tap)
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int MEMOP_W    = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    ex_mem_pipe_if.slave bus
);

    // Payload packing: {wd, wreg, wdata, mem_op, mem_addr}
    localparam int c_PW       = REG_ADDR_W + 1 + DATA_W + MEMOP_W + DATA_W;
    localparam int c_ADDR_LSB = 0;
    localparam int c_OP_LSB   = c_ADDR_LSB + DATA_W;
    localparam int c_DATA_LSB = c_OP_LSB + MEMOP_W;
    localparam int c_WREG_BIT = c_DATA_LSB + DATA_W;
    localparam int c_WD_LSB   = c_WREG_BIT + 1;

    pipe_state_e     r_state;

    logic            w_head_valid;
    logic            w_skid_valid;
    logic [c_PW-1:0] w_head_q;
    logic [c_PW-1:0] w_skid_q;
    logic [c_PW-1:0] w_ex_pl;
    logic [c_PW-1:0] w_head_d;

    logic            w_accept;
    logic            w_pop;
    logic            w_flush;
    logic            w_head_load;
    logic            w_head_clear;
    logic            w_skid_load;
    logic            w_skid_clear;

    logic [REG_ADDR_W-1:0] w_head_wd;
    logic                  w_head_wreg;

    // rst_n is folded in so ex_ready reads low while reset is asserted,
    // yet the very first edge after release can already accept.
    assign bus.ex_ready = bus.rdy & ~w_skid_valid & (rst_n != RST_ACTIVE);

    assign w_accept = bus.ex_valid & bus.ex_ready;
    assign w_pop    = w_head_valid & bus.mem_ready & bus.rdy;
    assign w_flush  = bus.flush & bus.rdy;

    assign w_ex_pl  = {bus.ex_wd, bus.ex_wreg, bus.ex_wdata,
                       bus.ex_mem_op, bus.ex_mem_addr};

    // In TWO the head can only be refilled from the skid; otherwise from EX.
    assign w_head_d = (r_state == ST_TWO) ? w_skid_q : w_ex_pl;

    always_comb begin
        w_head_load  = 1'b0;
        w_head_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (w_flush) begin
            w_head_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: w_head_load = w_accept;
                ST_ONE: begin
                    if (w_accept && w_pop) w_head_load  = 1'b1;
                    else if (w_accept)     w_skid_load  = 1'b1;
                    else if (w_pop)        w_head_clear = 1'b1;
                end
                ST_TWO: begin
                    w_head_load  = w_pop;
                    w_skid_clear = w_pop;
                end
                default: begin
                    w_head_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACTIVE) begin
            r_state <= ST_EMPTY;
        end else if (w_flush) begin
            r_state <= ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) r_state <= ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_pop)      r_state <= ST_TWO;
                    else if (w_pop && !w_accept) r_state <= ST_EMPTY;
                end
                ST_TWO:   if (w_pop) r_state <= ST_ONE;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    pipe_slot #(.W(c_PW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_head_load),
        .clear (w_head_clear),
        .d     (w_head_d),
        .valid (w_head_valid),
        .q     (w_head_q)
    );

    pipe_slot #(.W(c_PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_skid_load),
        .clear (w_skid_clear),
        .d     (w_ex_pl),
        .valid (w_skid_valid),
        .q     (w_skid_q)
    );

    assign w_head_wd   = w_head_q[c_WD_LSB +: REG_ADDR_W];
    assign w_head_wreg = w_head_q[c_WREG_BIT];

    // An empty head must look like a NOP downstream.
    assign bus.mem_valid    = w_head_valid;
    assign bus.mem_wd       = w_head_wd;
    assign bus.mem_wreg     = w_head_valid ? w_head_wreg : WRITE_DISABLE;
    assign bus.mem_wdata    = w_head_q[c_DATA_LSB +: DATA_W];
    assign bus.mem_mem_op   = w_head_valid ? w_head_q[c_OP_LSB +: MEMOP_W]
                                           : MEMOP_W'(MEM_NOP);
    assign bus.mem_mem_addr = w_head_q[c_ADDR_LSB +: DATA_W];

    // Writes to x0 are architecturally discarded, so never forward them.
    assign bus.fwd_wd    = w_head_wd;
    assign bus.fwd_wdata = w_head_q[c_DATA_LSB +: DATA_W];
    assign bus.fwd_wreg  = w_head_valid & w_head_wreg
                         & (w_head_wd != REG_ADDR_W'(NOP_REG_ADDR));

endmodule : ex_mem_pipe
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_pipe
// Description : Directed self-checking bench for ex_mem_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_pipe;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    ex_mem_pipe_if #(.REG_ADDR_W(5), .DATA_W(32), .MEMOP_W(4)) bus ();

    ex_mem_pipe #(.REG_ADDR_W(5), .DATA_W(32), .MEMOP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] wd, input logic wreg,
                         input logic [31:0] wdata, input logic [3:0] op);
        bus.ex_valid    = v;
        bus.ex_wd       = wd;
        bus.ex_wreg     = wreg;
        bus.ex_wdata    = wdata;
        bus.ex_mem_op   = op;
        bus.ex_mem_addr = wdata ^ 32'h0000_1000;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n         = 1'b0;
        bus.rdy       = 1'b1;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0, 4'd0);

        // Reset state
        #3;
        chk("rst_ex_ready",  bus.ex_ready,  1'b0);
        chk("rst_mem_valid", bus.mem_valid, 1'b0);
        chk("rst_mem_wreg",  bus.mem_wreg,  1'b0);
        chk("rst_fwd_wreg",  bus.fwd_wreg,  1'b0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ex_ready", bus.ex_ready, 1'b1);

        // Single pass, 1-cycle latency
        bus.mem_ready = 1'b1;
        drive(1'b1, 5'd5, 1'b1, 32'h1234_5678, 4'd3);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 4'd0);
        chk("sp_mem_valid", bus.mem_valid,    1'b1);
        chk("sp_mem_wd",    bus.mem_wd,       5'd5);
        chk("sp_mem_wdata", bus.mem_wdata,    32'h1234_5678);
        chk("sp_mem_op",    bus.mem_mem_op,   4'd3);
        chk("sp_mem_addr",  bus.mem_mem_addr, 32'h1234_4678);
        chk("sp_fwd_wreg",  bus.fwd_wreg,     1'b1);
        chk("sp_fwd_wdata", bus.fwd_wdata,    32'h1234_5678);
        step();
        chk("sp_drain_valid", bus.mem_valid,  1'b0);
        chk("sp_drain_wreg",  bus.mem_wreg,   1'b0);
        chk("sp_drain_op",    bus.mem_mem_op, 4'd0);

        // Back-pressure: A into head, B into skid
        bus.mem_ready = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 32'hAAAA_0001, 4'd1);
        step();
        chk("bp_a_head",  bus.mem_wdata, 32'hAAAA_0001);
        chk("bp_a_ready", bus.ex_ready,  1'b1);
        drive(1'b1, 5'd2, 1'b1, 32'hBBBB_0002, 4'd8);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 4'd0);
        chk("bp_b_skid_ready", bus.ex_ready,  1'b0);
        chk("bp_head_still_a", bus.mem_wdata, 32'hAAAA_0001);
        step();
        chk("bp_hold_ready", bus.ex_ready,  1'b0);
        chk("bp_hold_valid", bus.mem_valid, 1'b1);
        bus.mem_ready = 1'b1;
        #1;
        chk("bp_a_out", bus.mem_wdata, 32'hAAAA_0001);
        step();
        chk("bp_b_out",    bus.mem_wdata,  32'hBBBB_0002);
        chk("bp_b_wd",     bus.mem_wd,     5'd2);
        chk("bp_b_op",     bus.mem_mem_op, 4'd8);
        chk("bp_ready_up", bus.ex_ready,   1'b1);
        step();
        chk("bp_empty", bus.mem_valid, 1'b0);

        // Flush from TWO with an offered entry C
        bus.mem_ready = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 32'h3333_0003, 4'd2);
        step();
        drive(1'b1, 5'd4, 1'b1, 32'h4444_0004, 4'd2);
        step();
        chk("fl_two", bus.ex_ready, 1'b0);
        bus.flush = 1'b1;
        drive(1'b1, 5'd12, 1'b1, 32'hCCCC_000C, 4'd6);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0, 4'd0);
        chk("fl_valid", bus.mem_valid, 1'b0);
        chk("fl_wreg",  bus.mem_wreg,  1'b0);
        chk("fl_ready", bus.ex_ready,  1'b1);
        step();
        chk("fl_no_c", bus.mem_valid, 1'b0);

        // Pause with rdy low
        drive(1'b1, 5'd6, 1'b1, 32'hDDDD_0006, 4'd7);
        step();
        chk("pz_head", bus.mem_wdata, 32'hDDDD_0006);
        bus.rdy       = 1'b0;
        bus.flush     = 1'b1;
        bus.mem_ready = 1'b1;
        drive(1'b1, 5'd14, 1'b1, 32'hEEEE_000E, 4'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("pz_valid", bus.mem_valid, 1'b1);
            chk("pz_data",  bus.mem_wdata, 32'hDDDD_0006);
            chk("pz_ready", bus.ex_ready,  1'b0);
        end
        bus.rdy   = 1'b1;
        bus.flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0, 4'd0);
        #1;
        chk("pz_resume_data", bus.mem_wdata, 32'hDDDD_0006);
        step();
        chk("pz_consumed", bus.mem_valid, 1'b0);

        // Write to x0
        bus.mem_ready = 1'b0;
        drive(1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF, 4'd0);
        step();
        chk("x0_valid",    bus.mem_valid, 1'b1);
        chk("x0_mem_wreg", bus.mem_wreg,  1'b1);
        chk("x0_fwd_wreg", bus.fwd_wreg,  1'b0);

        // Asynchronous reset while in TWO
        drive(1'b1, 5'd7, 1'b1, 32'h7777_0007, 4'd5);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 4'd0);
        chk("ar_two", bus.ex_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bus.mem_valid, 1'b0);
        chk("ar_ready", bus.ex_ready,  1'b0);
        chk("ar_fwd",   bus.fwd_wreg,  1'b0);
        #2;
        rst_n = 1'b1;
        step();
        chk("ar_empty_valid", bus.mem_valid, 1'b0);
        chk("ar_empty_ready", bus.ex_ready,  1'b1);
        drive(1'b1, 5'd9, 1'b1, 32'h9999_0009, 4'd3);
        step();
        drive(1'b0, 5'd0, 1'b0, 32'h0, 4'd0);
        chk("ar_after_data", bus.mem_wdata, 32'h9999_0009);
        chk("ar_after_fwd",  bus.fwd_wreg,  1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ex_mem_pipe
`default_nettype wire

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, destination register address width.
REQ-002 SHALL have parameter DATA_W, default 32, result and memory address width.
REQ-003 SHALL have parameter MEMOP_W, default 4, memory-operation code width; code 0 means no memory access.
REQ-004 SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rdy  input  1  global enable; low freezes all state.
- flush  input  1  synchronous kill of all held entries.
- ex_valid  input  1  upstream entry present.
- ex_ready  output  1  block accepts an entry this cycle.
- ex_wd  input  REG_ADDR_W  destination register.
- ex_wreg  input  1  register write enable.
- ex_wdata  input  DATA_W  ALU result.
- ex_mem_op  input  MEMOP_W  memory-operation code.
- ex_mem_addr  input  DATA_W  effective address.
- mem_valid  output  1  head entry present.
- mem_ready  input  1  downstream consumes the head entry.
- mem_wd, mem_wreg, mem_wdata, mem_mem_op, mem_mem_addr  outputs  widths as ex_*  head entry payload.
- fwd_wd  output  REG_ADDR_W  forwarding tap, head destination register.
- fwd_wreg  output  1  forwarding tap, head write enable.
- fwd_wdata  output  DATA_W  forwarding tap, head data.

Function
REQ-005 SHALL hold at most two entries: a head register that drives mem_* and a skid register.
REQ-006 SHALL have three states: EMPTY (none held), ONE (head only) and TWO (head and skid).
REQ-007 SHALL drive ex_ready = rdy & ~skid_valid, from registered state only, with no combinational path from mem_ready.
REQ-008 SHALL define an accept as ex_valid & ex_ready, and a pop as mem_valid & mem_ready & rdy.
REQ-009 SHALL, in EMPTY on accept, load the head; mem_valid rises the next cycle, giving 1-cycle latency.
REQ-010 SHALL, in ONE:
- on accept with pop, replace the head (stay ONE);
- on accept without pop, load the skid (go to TWO);
- on pop without accept, go to EMPTY.
REQ-011 SHALL, in TWO on pop, move the skid into the head and go to ONE; no accept is possible in TWO.
REQ-012 SHALL deliver entries in acceptance order with no loss or duplication.
REQ-013 SHALL, when flush is high and rdy is high, go to EMPTY at the next edge and discard any same-cycle accept; flush overrides pop and accept.
REQ-014 SHALL, when rdy is low, hold state, valids and payloads unchanged, ignoring flush, accept and pop.
REQ-015 SHALL force mem_wreg = 0 and mem_mem_op = 0 whenever mem_valid = 0, so a bubble is a NOP.
REQ-016 SHALL drive fwd_wreg = mem_valid & head wreg, with fwd_wd and fwd_wdata equal to the head payload.
REQ-017 SHALL force fwd_wreg = 0 when the head wd is 0.
REQ-018 SHALL pass payload bits unmodified, with no width conversion.

Reset
REQ-019 SHALL, while rst_n = 0, asynchronously clear both valids and enter EMPTY.
REQ-020 SHALL reset payload registers to the no-op register address (0) and the zero word (0).
REQ-021 SHALL, during reset, drive ex_ready = 0, mem_valid = 0, mem_wreg = 0 and fwd_wreg = 0.
REQ-022 SHALL make the first accept possible on the first rising edge after rst_n deasserts with rdy high.
REQ-023 SHALL discard all held entries on reset mid-operation.

Structure
REQ-024 SHALL take the reset-active-low, write enable/disable and NOP register address constants from the shared defines file.
REQ-025 SHALL add to the shared defines file the memory-op codes (MEM_NOP = 0, LB, LH, LW, LBU, LHU, SB, SH, SW) and the active-low reset constant.
REQ-026 SHALL instantiate one sub-module, pipe_slot, twice: a valid bit plus payload register with load and clear, used for both head and skid.

Verification
REQ-027 SHALL cover single pass:
- stimulus: reset; ex_valid=1, wd=5, wreg=1, wdata=0x12345678, mem_ready=1;
- response: next cycle mem_valid=1, mem_wd=5, mem_wdata=0x12345678, fwd_wreg=1.
REQ-028 SHALL cover back-pressure:
- stimulus: mem_ready=0; ex_valid=1 for entries A and B;
- response: the B accept asserts skid_valid; the following cycle ex_ready=0;
- response: raise mem_ready; A then B appear on consecutive cycles, then ex_ready=1.
REQ-029 SHALL cover flush:
- stimulus: TWO state; flush=1 together with ex_valid=1, entry C;
- response: next cycle mem_valid=0, mem_wreg=0; C never appears.
REQ-030 SHALL cover pause:
- stimulus: ONE state; rdy=0 for 3 cycles with ex_valid=1, mem_ready=1, flush=1;
- response: outputs unchanged, ex_ready=0; after rdy=1 the original head is consumed.
REQ-031 SHALL cover the x0 write:
- stimulus: ex_wd=0, wreg=1, wdata=0xFFFFFFFF;
- response: mem_wreg=1, fwd_wreg=0.
REQ-032 SHALL cover asynchronous reset mid-stream:
- stimulus: rst_n=0 between clock edges while in TWO;
- response: mem_valid=0 immediately; EMPTY after release.
